// File: rtl/jt1942_dwnld_tx_if.sv
// Byte source handshake plus the ioctl download bus driven toward the ROM loaders.
interface jt1942_dwnld_tx_if;
    localparam int unsigned ADDR_W = 22;
    localparam int unsigned DATA_W = 8;

    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              downloading;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [DATA_W-1:0] ioctl_data;
    logic              ioctl_wr;

    modport master (
        input  src_valid, src_data,
        output src_ready, downloading, ioctl_addr, ioctl_data, ioctl_wr
    );

    modport slave (
        output src_valid, src_data,
        input  src_ready, downloading, ioctl_addr, ioctl_data, ioctl_wr
    );
endinterface

// File: rtl/jt1942_dwnld_tx.sv
// ioctl download transmitter: pulls bytes from a ready/valid source and frames
// them as a ROM download with one ioctl_wr strobe per byte at incrementing addresses.
module jt1942_dwnld_tx #(
    parameter int unsigned LEN         = 32'h15000 + 32'd32768,
    parameter int unsigned PRE_CYCLES  = 16,
    parameter int unsigned WR_GAP      = 3,
    parameter int unsigned POST_CYCLES = 16
) (
    input  logic                   clk_rom,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    jt1942_dwnld_tx_if.master      bus,
    output logic                   busy,
    output logic                   done
);
    localparam int unsigned ADDR_W = 22;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN - 32'd1);
    localparam logic [CNT_W-1:0]  PRE_LOAD  = CNT_W'(PRE_CYCLES);
    // GAP and POST load one less so the state lasts exactly the parameter count
    localparam logic [CNT_W-1:0]  GAP_LOAD  = (WR_GAP == 0) ? '0 : CNT_W'(WR_GAP - 32'd1);
    localparam logic [CNT_W-1:0]  POST_LOAD = (POST_CYCLES == 0) ? '0 : CNT_W'(POST_CYCLES - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_WR,
        S_GAP,
        S_POST
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [DATA_W-1:0]   data_nx;
    logic                done_nx;

    // Next-state, counter and datapath decisions
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        addr_nx  = bus.ioctl_addr;
        data_nx  = bus.ioctl_data;
        done_nx  = 1'b0;

        if (state != S_IDLE && abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nx = S_PRE;
                        cnt_nx   = PRE_LOAD;
                        addr_nx  = '0;
                    end
                end
                S_PRE: begin
                    if (cnt == '0) state_nx = S_WAIT;
                    else           cnt_nx   = cnt - CNT_W'(1);
                end
                S_WAIT: begin
                    if (bus.src_valid && bus.src_ready) begin
                        data_nx  = bus.src_data;
                        state_nx = S_WR;
                    end
                end
                S_WR: begin
                    if (bus.ioctl_addr == LAST_ADDR) begin
                        if (POST_CYCLES == 0) begin
                            state_nx = S_IDLE;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = S_POST;
                            cnt_nx   = POST_LOAD;
                        end
                    end else begin
                        addr_nx = bus.ioctl_addr + ADDR_W'(1);
                        if (WR_GAP == 0) begin
                            state_nx = S_WAIT;
                        end else begin
                            state_nx = S_GAP;
                            cnt_nx   = GAP_LOAD;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt == '0) state_nx = S_WAIT;
                    else           cnt_nx   = cnt - CNT_W'(1);
                end
                S_POST: begin
                    if (cnt == '0) begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt - CNT_W'(1);
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // State and registered outputs; flags decode the upcoming state so they align with it
    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            bus.src_ready   <= 1'b0;
            bus.downloading <= 1'b0;
            bus.ioctl_addr  <= '0;
            bus.ioctl_data  <= '0;
            bus.ioctl_wr    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            bus.src_ready   <= (state_nx == S_WAIT);
            bus.downloading <= (state_nx != S_IDLE);
            bus.ioctl_addr  <= addr_nx;
            bus.ioctl_data  <= data_nx;
            bus.ioctl_wr    <= (state_nx == S_WR);
            busy            <= (state_nx != S_IDLE);
            done            <= done_nx;
        end
    end
endmodule

// File: tb/tb_jt1942_dwnld_tx.sv
// Directed bench for jt1942_dwnld_tx: three parameterisations, one active at a time.
module tb_jt1942_dwnld_tx;
    typedef struct packed {
        logic        ready;
        logic        dl;
        logic        wr;
        logic        busy;
        logic        done;
        logic [21:0] addr;
        logic [7:0]  data;
    } obs_t;

    typedef struct {
        logic start;
        logic valid;
        obs_t want;
    } vec_t;

    logic       clk_rom;
    logic       rst;
    logic       start;
    logic       abort;
    logic       src_valid;
    logic [7:0] src_base;
    logic [7:0] src_idx;
    logic [7:0] src_data;
    logic       src_clr;
    logic [1:0] sel;
    obs_t       obs;

    int checks = 0;
    int errors = 0;

    logic start_a, start_b, start_c, abort_a, abort_b, abort_c;
    logic busy_a, busy_b, busy_c, done_a, done_b, done_c;

    jt1942_dwnld_tx_if ifa ();
    jt1942_dwnld_tx_if ifb ();
    jt1942_dwnld_tx_if ifc ();

    assign start_a = start && (sel == 2'd0);
    assign start_b = start && (sel == 2'd1);
    assign start_c = start && (sel == 2'd2);
    assign abort_a = abort && (sel == 2'd0);
    assign abort_b = abort && (sel == 2'd1);
    assign abort_c = abort && (sel == 2'd2);

    assign ifa.src_valid = src_valid;
    assign ifb.src_valid = src_valid;
    assign ifc.src_valid = src_valid;
    assign ifa.src_data  = src_data;
    assign ifb.src_data  = src_data;
    assign ifc.src_data  = src_data;

    jt1942_dwnld_tx #(.LEN(4), .PRE_CYCLES(2), .WR_GAP(1), .POST_CYCLES(3)) dut_a (
        .clk_rom(clk_rom), .rst(rst), .start(start_a), .abort(abort_a),
        .bus(ifa.master), .busy(busy_a), .done(done_a)
    );
    jt1942_dwnld_tx #(.LEN(4), .PRE_CYCLES(0), .WR_GAP(0), .POST_CYCLES(1)) dut_b (
        .clk_rom(clk_rom), .rst(rst), .start(start_b), .abort(abort_b),
        .bus(ifb.master), .busy(busy_b), .done(done_b)
    );
    jt1942_dwnld_tx #(.LEN(1), .PRE_CYCLES(1), .WR_GAP(2), .POST_CYCLES(2)) dut_c (
        .clk_rom(clk_rom), .rst(rst), .start(start_c), .abort(abort_c),
        .bus(ifc.master), .busy(busy_c), .done(done_c)
    );

    always_comb begin
        case (sel)
            2'd0:    obs = {ifa.src_ready, ifa.downloading, ifa.ioctl_wr, busy_a, done_a, ifa.ioctl_addr, ifa.ioctl_data};
            2'd1:    obs = {ifb.src_ready, ifb.downloading, ifb.ioctl_wr, busy_b, done_b, ifb.ioctl_addr, ifb.ioctl_data};
            default: obs = {ifc.src_ready, ifc.downloading, ifc.ioctl_wr, busy_c, done_c, ifc.ioctl_addr, ifc.ioctl_data};
        endcase
    end

    // Byte source: offers src_base + number of bytes already accepted
    assign src_data = src_base + src_idx;
    always @(posedge clk_rom or posedge src_clr) begin
        if (src_clr)                     src_idx <= 8'd0;
        else if (src_valid && obs.ready) src_idx <= src_idx + 8'd1;
    end

    initial clk_rom = 1'b0;
    always #5 clk_rom = ~clk_rom;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_rom);
        start = 1'b0;
    endtask

    task automatic new_source(input logic [7:0] base);
        src_base = base;
        src_clr  = 1'b1;
        #1;
        src_clr  = 1'b0;
    endtask

    task automatic wait_wr(input string name, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (obs.wr) begin
                ok = 1;
                break;
            end
            @(negedge clk_rom);
        end
        check(name, 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (obs.done) begin
                ok = 1;
                break;
            end
            @(negedge clk_rom);
        end
        check(name, 64'(ok), 64'd1);
    endtask

    function automatic vec_t row(input logic st, input logic vl, input logic rd, input logic d,
                                 input logic w, input logic b, input logic dn,
                                 input logic [21:0] a, input logic [7:0] dt);
        vec_t r;
        r.start = st;
        r.valid = vl;
        r.want  = {rd, d, w, b, dn, a, dt};
        return r;
    endfunction

    vec_t tbl[19];

    initial begin
        int n;
        int last;
        int dcnt;
        bit bad_addr;

        // start, valid | ready, dl, wr, busy, done, addr, data
        tbl[0]  = row(1, 1, 0, 1, 0, 1, 0, 22'd0, 8'h00);
        tbl[1]  = row(0, 1, 0, 1, 0, 1, 0, 22'd0, 8'h00);
        tbl[2]  = row(0, 1, 0, 1, 0, 1, 0, 22'd0, 8'h00);
        tbl[3]  = row(0, 1, 1, 1, 0, 1, 0, 22'd0, 8'h00);
        tbl[4]  = row(0, 1, 0, 1, 1, 1, 0, 22'd0, 8'hA0);
        tbl[5]  = row(0, 1, 0, 1, 0, 1, 0, 22'd1, 8'hA0);
        tbl[6]  = row(0, 1, 1, 1, 0, 1, 0, 22'd1, 8'hA0);
        tbl[7]  = row(0, 1, 0, 1, 1, 1, 0, 22'd1, 8'hA1);
        tbl[8]  = row(1, 1, 0, 1, 0, 1, 0, 22'd2, 8'hA1);
        tbl[9]  = row(0, 1, 1, 1, 0, 1, 0, 22'd2, 8'hA1);
        tbl[10] = row(0, 1, 0, 1, 1, 1, 0, 22'd2, 8'hA2);
        tbl[11] = row(0, 1, 0, 1, 0, 1, 0, 22'd3, 8'hA2);
        tbl[12] = row(0, 1, 1, 1, 0, 1, 0, 22'd3, 8'hA2);
        tbl[13] = row(0, 1, 0, 1, 1, 1, 0, 22'd3, 8'hA3);
        tbl[14] = row(0, 1, 0, 1, 0, 1, 0, 22'd3, 8'hA3);
        tbl[15] = row(0, 1, 0, 1, 0, 1, 0, 22'd3, 8'hA3);
        tbl[16] = row(0, 1, 0, 1, 0, 1, 0, 22'd3, 8'hA3);
        tbl[17] = row(0, 1, 0, 0, 0, 0, 1, 22'd3, 8'hA3);
        tbl[18] = row(0, 1, 0, 0, 0, 0, 0, 22'd3, 8'hA3);

        rst = 1'b0; start = 1'b0; abort = 1'b0; src_valid = 1'b0;
        src_base = 8'h00; src_clr = 1'b0; sel = 2'd0;
        #2 rst = 1'b1;
        new_source(8'h00);
        repeat (2) @(negedge clk_rom);
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            check($sformatf("reset dut%0d", k), 64'(obs), 64'd0);
        end
        sel = 2'd0;
        @(negedge clk_rom);
        rst = 1'b0;
        @(negedge clk_rom);

        // Basic download, cycle by cycle (row 8 also pulses an ignored start during WR)
        new_source(8'hA0);
        for (int i = 0; i < 19; i++) begin
            start     = tbl[i].start;
            src_valid = tbl[i].valid;
            @(negedge clk_rom);
            check($sformatf("basic cycle %0d", i), 64'(obs), 64'(tbl[i].want));
        end
        start = 1'b0;

        // Back-to-back writes with no gap
        sel = 2'd1;
        new_source(8'h10);
        src_valid = 1'b1;
        @(negedge clk_rom);
        pulse_start();
        n = 0; last = 0; dcnt = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (obs.wr) begin
                check($sformatf("b2b addr %0d", n), 64'(obs.addr), 64'(n));
                check($sformatf("b2b data %0d", n), 64'(obs.data), 64'(8'h10 + 8'(n)));
                if (n == 0) check("b2b first strobe cycle", 64'(cyc), 64'd2);
                else        check($sformatf("b2b period %0d", n), 64'(cyc - last), 64'd2);
                last = cyc;
                n++;
            end
            if (obs.done) begin
                check("b2b done cycle", 64'(cyc), 64'd10);
                dcnt++;
            end
            @(negedge clk_rom);
        end
        check("b2b strobe count", 64'(n), 64'd4);
        check("b2b done count", 64'(dcnt), 64'd1);

        // Source stall before byte 2
        sel = 2'd0;
        new_source(8'h30);
        @(negedge clk_rom);
        pulse_start();
        wait_wr("stall wr0", 20);
        @(negedge clk_rom);
        wait_wr("stall wr1", 10);
        check("stall addr1", 64'(obs.addr), 64'd1);
        src_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_rom);
            check($sformatf("stall hold %0d", i), 64'({obs.wr, obs.dl}), 64'b01);
        end
        src_valid = 1'b1;
        @(negedge clk_rom);
        wait_wr("stall wr2", 10);
        check("stall addr2", 64'({obs.addr, obs.data}), 64'({22'd2, 8'h32}));
        @(negedge clk_rom);
        wait_wr("stall wr3", 10);
        check("stall addr3", 64'({obs.addr, obs.data}), 64'({22'd3, 8'h33}));
        wait_done("stall done", 20);

        // Abort in GAP after byte 1, then restart from address 0
        @(negedge clk_rom);
        new_source(8'h40);
        pulse_start();
        wait_wr("abort wr0", 20);
        @(negedge clk_rom);
        wait_wr("abort wr1", 10);
        @(negedge clk_rom);
        check("abort in gap", 64'({obs.ready, obs.wr, obs.busy}), 64'b001);
        abort = 1'b1;
        @(negedge clk_rom);
        abort = 1'b0;
        check("abort outputs", 64'({obs.ready, obs.dl, obs.wr, obs.busy, obs.done}), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_rom);
            if (obs.done || obs.busy) dcnt++;
        end
        check("abort stays idle", 64'(dcnt), 64'd0);
        new_source(8'h50);
        pulse_start();
        wait_wr("restart wr0", 20);
        check("restart addr0", 64'({obs.addr, obs.data}), 64'({22'd0, 8'h50}));
        wait_done("restart done", 40);

        // Ignored start in WAIT_SRC, then async reset mid-GAP
        @(negedge clk_rom);
        new_source(8'h60);
        pulse_start();
        wait_wr("ign wr0", 20);
        src_valid = 1'b0;
        @(negedge clk_rom);
        @(negedge clk_rom);
        check("ign in wait", 64'({obs.ready, obs.addr}), 64'({1'b1, 22'd1}));
        pulse_start();
        check("ign start 1", 64'({obs.busy, obs.ready, obs.addr}), 64'({2'b11, 22'd1}));
        @(negedge clk_rom);
        check("ign start 2", 64'({obs.busy, obs.ready, obs.dl, obs.addr}), 64'({3'b111, 22'd1}));
        src_valid = 1'b1;
        wait_wr("ign wr1", 10);
        check("ign addr1", 64'({obs.addr, obs.data}), 64'({22'd1, 8'h61}));
        @(negedge clk_rom);
        check("rst in gap", 64'({obs.busy, obs.wr, obs.ready}), 64'b100);
        #2 rst = 1'b1;
        #1 check("async reset", 64'(obs), 64'd0);
        @(negedge clk_rom);
        rst = 1'b0;
        @(negedge clk_rom);

        // LEN=1: single strobe at address 0
        sel = 2'd2;
        new_source(8'h70);
        src_valid = 1'b1;
        pulse_start();
        n = 0; dcnt = 0; bad_addr = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (obs.addr != 22'd0) bad_addr = 1;
            if (obs.wr) begin
                check("len1 strobe", 64'({obs.addr, obs.data}), 64'({22'd0, 8'h70}));
                check("len1 strobe cycle", 64'(cyc), 64'd3);
                n++;
            end
            if (obs.done) begin
                check("len1 done cycle", 64'(cyc), 64'd6);
                dcnt++;
            end
            @(negedge clk_rom);
        end
        check("len1 strobe count", 64'(n), 64'd1);
        check("len1 done count", 64'(dcnt), 64'd1);
        check("len1 addr stayed 0", 64'(bad_addr), 64'd0);
        check("len1 idle", 64'({obs.busy, obs.dl}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
